// File: rtl/win_sum_pkg.sv
// Shared constants and helpers for the 1-D sliding-window summer.
// Imported by the per-channel datapath and the control top level.
package win_sum_pkg;

    localparam int DW_DEF      = 8;
    localparam int CH_DEF      = 1;
    localparam int KSZ_MAX_DEF = 7;
    localparam int OW_DEF      = DW_DEF + 3;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >>> 1;
        end
        return r;
    endfunction

    function automatic int ch_lo(input int c, input int w);
        return c * w;
    endfunction

    // A zero window still passes the sample through; long windows saturate.
    function automatic int clamp_k(input int k, input int kmax);
        if (k == 0) begin
            return 1;
        end
        if (k > kmax) begin
            return kmax;
        end
        return k;
    endfunction

endpackage

// File: rtl/win_sum_ch.sv
// One channel: sample delay line, window tap select, running
// accumulator and normalised output register.
module win_sum_ch
    import win_sum_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int KSZ_MAX = KSZ_MAX_DEF,
    parameter int KW      = clog2(KSZ_MAX + 1),
    parameter int OW      = OW_DEF,
    parameter int SHW     = clog2(OW)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  x,
    input  logic           x_valid,
    input  logic           line_start,
    input  logic           sub_en,
    input  logic [KW-1:0]  tap_sel,
    input  logic           out_en,
    input  logic [SHW-1:0] shift,
    output logic [OW-1:0]  y
);

    logic [DW-1:0] dl [KSZ_MAX];
    logic [DW-1:0] tap;
    logic [OW-1:0] acc;
    logic [OW-1:0] acc_nxt;

    always_comb begin
        tap = '0;
        for (int i = 0; i < KSZ_MAX; i++) begin
            if (int'(tap_sel) == i) begin
                tap = dl[i];
            end
        end
    end

    always_comb begin
        acc_nxt = (line_start ? '0 : acc) + OW'(x);
        if (sub_en) begin
            acc_nxt = acc_nxt - OW'(tap);
        end
    end

    // Stale taps are never selected before the line rewrites them.
    always_ff @(posedge clk) begin
        if (x_valid) begin
            dl[0] <= x;
            for (int i = 1; i < KSZ_MAX; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            y   <= '0;
        end else begin
            if (x_valid) begin
                acc <= acc_nxt;
            end
            if (out_en) begin
                y <= acc >> shift;
            end
        end
    end

endmodule

// File: rtl/win_sum_1d.sv
// Multi-channel runtime-configurable 1-D sliding-window summer.
// Shared line control here; per-channel datapath in win_sum_ch.
module win_sum_1d
    import win_sum_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int CH      = CH_DEF,
    parameter int KSZ_MAX = KSZ_MAX_DEF,
    parameter int KW      = clog2(KSZ_MAX + 1),
    parameter int OW      = DW + 3,
    parameter int SHW     = clog2(OW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*DW-1:0]  din,
    input  logic              din_valid,
    input  logic [KW-1:0]     ksz,
    input  logic [SHW-1:0]    shift,
    output logic [CH*OW-1:0]  dout,
    output logic              dout_valid
);

    logic           v1;
    logic [KW-1:0]  k_lat;
    logic [KW-1:0]  cnt;
    logic [SHW-1:0] sh_lat;
    logic [KW-1:0]  k_in;
    logic [KW-1:0]  tap_sel;
    logic           start;
    logic           sub_en;

    always_comb begin
        k_in    = KW'(clamp_k(int'(ksz), KSZ_MAX));
        start   = din_valid && !v1;
        sub_en  = !start && (cnt >= k_lat);
        tap_sel = k_lat - KW'(1);
    end

    // v1 doubles as previous-cycle valid for line-start detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            dout_valid <= 1'b0;
            cnt        <= '0;
            k_lat      <= KW'(1);
            sh_lat     <= '0;
        end else begin
            v1         <= din_valid;
            dout_valid <= v1;
            if (start) begin
                k_lat  <= k_in;
                sh_lat <= shift;
                cnt    <= KW'(1);
            end else if (din_valid) begin
                cnt <= (cnt >= k_lat) ? k_lat : cnt + KW'(1);
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        win_sum_ch #(
            .DW      (DW),
            .KSZ_MAX (KSZ_MAX),
            .KW      (KW),
            .OW      (OW),
            .SHW     (SHW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .x          (din[ch_lo(c, DW) +: DW]),
            .x_valid    (din_valid),
            .line_start (start),
            .sub_en     (sub_en),
            .tap_sel    (tap_sel),
            .out_en     (v1),
            .shift      (sh_lat),
            .y          (dout[ch_lo(c, OW) +: OW])
        );
    end

endmodule

// File: tb/tb_win_sum_1d.sv
// Randomised and directed bench for win_sum_1d, checked against a
// queue-based window-sum model.
module tb_win_sum_1d;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int KM = 7;
    localparam int KW = 4;
    localparam int OW = 11;
    localparam int SW = 4;

    typedef struct {
        bit r;
        bit v;
        int a;
        int b;
        int k;
        int s;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CH*DW-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic [KW-1:0]    ksz = '0;
    logic [SW-1:0]    shift = '0;
    logic [CH*OW-1:0] dout;
    logic             dout_valid;

    int total = 0;
    int bad = 0;

    bit prev_v = 0;
    int q0[$];
    int q1[$];
    int kl = 1;
    int sl = 0;
    bit pend_v = 0;
    int pend0 = 0;
    int pend1 = 0;
    int last0 = 0;
    int last1 = 0;

    win_sum_1d #(
        .DW(DW), .CH(CH), .KSZ_MAX(KM), .KW(KW), .OW(OW), .SHW(SW)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .ksz(ksz), .shift(shift), .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the model, return outputs expected after the edge.
    task automatic step(input vec_t t, output bit ev,
                        output logic [CH*OW-1:0] ed);
        bit nv;
        int n0;
        int n1;
        int s0;
        int s1;
        rst = t.r;
        din_valid = t.v;
        din = {8'(t.b), 8'(t.a)};
        ksz = 4'(t.k);
        shift = 4'(t.s);
        nv = 0;
        n0 = 0;
        n1 = 0;
        if (!t.r && t.v) begin
            if (!prev_v) begin
                q0.delete();
                q1.delete();
                kl = (t.k == 0) ? 1 : (t.k > KM ? KM : t.k);
                sl = t.s;
            end
            q0.push_back(t.a & 255);
            q1.push_back(t.b & 255);
            if (q0.size() > kl) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            s0 = 0;
            s1 = 0;
            foreach (q0[j]) s0 += q0[j];
            foreach (q1[j]) s1 += q1[j];
            nv = 1;
            n0 = s0 >> sl;
            n1 = s1 >> sl;
        end
        prev_v = t.r ? 1'b0 : t.v;
        @(posedge clk);
        #1;
        if (t.r) begin
            ev = 0;
            last0 = 0;
            last1 = 0;
        end else begin
            ev = pend_v;
            if (pend_v) begin
                last0 = pend0;
                last1 = pend1;
            end
        end
        ed = {11'(last1), 11'(last0)};
        pend_v = t.r ? 1'b0 : nv;
        pend0 = n0;
        pend1 = n1;
    endtask

    function automatic vec_t mk(bit r, bit v, int a, int b, int k, int s);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.b = b; t.k = k; t.s = s;
        return t;
    endfunction

    task automatic test_reset;
        bit ev;
        logic [CH*OW-1:0] ed;
        for (int i = 0; i < 3; i++) begin
            step(mk(1, i[0], 9, 9, 3, 0), ev, ed);
            total++;
            if (dout_valid !== 1'b0 || dout !== '0) begin
                bad++;
                $display("FAIL reset cyc%0d got v=%b d=%h want v=0 d=0",
                         i, dout_valid, dout);
            end
        end
    endtask

    task automatic test_basic;
        int xs[5] = '{1, 2, 3, 4, 5};
        int req[5] = '{1, 3, 6, 9, 12};
        int got[$];
        bit ev;
        logic [CH*OW-1:0] ed;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) step(mk(0, 1, xs[i], $urandom_range(0, 255), 3, 0), ev, ed);
            else step(mk(0, 0, 0, 0, 3, 0), ev, ed);
            total++;
            if (dout_valid !== ev || dout !== ed) begin
                bad++;
                $display("FAIL basic cyc%0d got v=%b d=%h want v=%b d=%h",
                         i, dout_valid, dout, ev, ed);
            end
            if (dout_valid === 1'b1) got.push_back(int'(dout[OW-1:0]));
        end
        total++;
        if (got.size() != 5) begin
            bad++;
            $display("FAIL basic_count got %0d want 5", got.size());
        end else begin
            foreach (req[i]) begin
                total++;
                if (got[i] != req[i]) begin
                    bad++;
                    $display("FAIL basic_val%0d got %0d want %0d", i, got[i], req[i]);
                end
            end
        end
    endtask

    task automatic test_restart;
        vec_t sq[$];
        bit ev;
        logic [CH*OW-1:0] ed;
        int got[$];
        int req[5] = '{1, 3, 6, 10, 20};
        sq.push_back(mk(0, 1, 1, 5, 3, 0));
        sq.push_back(mk(0, 1, 2, 5, 3, 0));
        sq.push_back(mk(0, 1, 3, 5, 3, 0));
        sq.push_back(mk(0, 0, 0, 0, 3, 0));
        sq.push_back(mk(0, 1, 10, 6, 3, 0));
        sq.push_back(mk(0, 1, 10, 6, 3, 0));
        sq.push_back(mk(0, 0, 0, 0, 3, 0));
        sq.push_back(mk(0, 0, 0, 0, 3, 0));
        foreach (sq[i]) begin
            step(sq[i], ev, ed);
            total++;
            if (dout_valid !== ev || dout !== ed) begin
                bad++;
                $display("FAIL restart cyc%0d got v=%b d=%h want v=%b d=%h",
                         i, dout_valid, dout, ev, ed);
            end
            if (dout_valid === 1'b1) got.push_back(int'(dout[OW-1:0]));
        end
        total++;
        if (got.size() != 5 || got[3] != req[3] || got[4] != req[4]) begin
            bad++;
            $display("FAIL restart_vals got n=%0d want 1,3,6,10,20", got.size());
        end
    endtask

    task automatic test_mean;
        int xs[5] = '{4, 8, 12, 16, 20};
        bit ev;
        logic [CH*OW-1:0] ed;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) step(mk(0, 1, xs[i], $urandom_range(0, 255), 4, 2), ev, ed);
            else step(mk(0, 0, 0, 0, 0, 0), ev, ed);
            total++;
            if (dout_valid !== ev || dout !== ed) begin
                bad++;
                $display("FAIL mean cyc%0d got v=%b d=%h want v=%b d=%h",
                         i, dout_valid, dout, ev, ed);
            end
        end
    endtask

    task automatic test_full_scale;
        bit ev;
        logic [CH*OW-1:0] ed;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) step(mk(0, 1, 255, 1, 7, 0), ev, ed);
            else step(mk(0, 0, 0, 0, 7, 0), ev, ed);
            total++;
            if (dout_valid !== ev || dout !== ed) begin
                bad++;
                $display("FAIL full_scale cyc%0d got v=%b d=%h want v=%b d=%h",
                         i, dout_valid, dout, ev, ed);
            end
        end
        total++;
        if (dout !== {11'd7, 11'd1785}) begin
            bad++;
            $display("FAIL full_scale_hold got %h want %h", dout, {11'd7, 11'd1785});
        end
    endtask

    task automatic test_clamp;
        vec_t sq[$];
        bit ev;
        logic [CH*OW-1:0] ed;
        for (int i = 0; i < 5; i++)
            sq.push_back(mk(0, 1, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0));
        sq.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++)
            sq.push_back(mk(0, 1, $urandom_range(0, 255), $urandom_range(0, 255), 9, 0));
        sq.push_back(mk(0, 0, 0, 0, 3, 0));
        for (int i = 0; i < 8; i++)
            sq.push_back(mk(0, 1, $urandom_range(0, 255), $urandom_range(0, 255),
                            i < 3 ? 3 : 5, i < 3 ? 0 : 3));
        sq.push_back(mk(0, 0, 0, 0, 5, 0));
        for (int i = 0; i < 8; i++)
            sq.push_back(mk(0, 1, $urandom_range(0, 255), $urandom_range(0, 255), 5, 0));
        sq.push_back(mk(0, 0, 0, 0, 5, 0));
        sq.push_back(mk(0, 0, 0, 0, 5, 0));
        foreach (sq[i]) begin
            step(sq[i], ev, ed);
            total++;
            if (dout_valid !== ev || dout !== ed) begin
                bad++;
                $display("FAIL clamp cyc%0d got v=%b d=%h want v=%b d=%h",
                         i, dout_valid, dout, ev, ed);
            end
        end
    endtask

    task automatic test_reset_midline;
        vec_t sq[$];
        bit ev;
        logic [CH*OW-1:0] ed;
        sq.push_back(mk(0, 1, 1, 2, 4, 0));
        sq.push_back(mk(0, 1, 2, 2, 4, 0));
        sq.push_back(mk(1, 1, 3, 2, 4, 0));
        sq.push_back(mk(0, 1, 7, 3, 4, 0));
        sq.push_back(mk(0, 1, 7, 3, 4, 0));
        sq.push_back(mk(0, 0, 0, 0, 4, 0));
        sq.push_back(mk(0, 0, 0, 0, 4, 0));
        foreach (sq[i]) begin
            step(sq[i], ev, ed);
            total++;
            if (dout_valid !== ev || dout !== ed) begin
                bad++;
                $display("FAIL reset_mid cyc%0d got v=%b d=%h want v=%b d=%h",
                         i, dout_valid, dout, ev, ed);
            end
            if (i == 2) begin
                total++;
                if (dout_valid !== 1'b0 || dout !== '0) begin
                    bad++;
                    $display("FAIL reset_mid_zero got v=%b d=%h want v=0 d=0",
                             dout_valid, dout);
                end
            end
        end
        total++;
        if (dout !== {11'd6, 11'd14}) begin
            bad++;
            $display("FAIL reset_mid_final got %h want %h", dout, {11'd6, 11'd14});
        end
    endtask

    task automatic test_random;
        bit ev;
        logic [CH*OW-1:0] ed;
        vec_t t;
        for (int i = 0; i < 600; i++) begin
            t = mk($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 15), $urandom_range(0, 4));
            step(t, ev, ed);
            total++;
            if (dout_valid !== ev || dout !== ed) begin
                bad++;
                $display("FAIL random cyc%0d got v=%b d=%h want v=%b d=%h",
                         i, dout_valid, dout, ev, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_mean();
        test_full_scale();
        test_clamp();
        test_reset_midline();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
